psola_ola_engine: RTL

- Parametrised TD-PSOLA overlap-add core, the next generation of the fixed 4-RAM pitch shifter.
- Cuts the input stream into triangular-windowed analysis grains every hop_in samples and stores them in NGRAIN grain buffers.
- Re-emits the newest grain every hop_out samples through NVOICE concurrent read voices and sums them.
- Pitch is shifted by the hop_in/hop_out ratio: grains are repeated or skipped as needed. Sits between the period detector/note selector (which supply win_len, hop_in, hop_out) and the audio output.

---
 rtl/psola_ola_engine.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/psola_ola_engine.sv
// TD-PSOLA overlap-add: windowed analysis grains written into NGRAIN buffers,
// replayed by NVOICE synthesis voices on the hop_out grid and summed.
module psola_ola_engine #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int MAX_WIN = 934,
    parameter int NGRAIN  = 6,
    parameter int NVOICE  = 3,
    parameter int SHIFT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  din,
    input  logic [ADDR_W-1:0]  win_len,
    input  logic [ADDR_W-1:0]  hop_in,
    input  logic [ADDR_W-1:0]  hop_out,
    input  logic [SHIFT_W-1:0] out_shift,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               overrun,
    output logic               voice_drop
);
    localparam int PW = DATA_W + ADDR_W;
    localparam int SW = PW + $clog2(NVOICE);
    localparam int GW = (NGRAIN > 1) ? $clog2(NGRAIN) : 1;
    localparam int VW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    logic [ADDR_W-1:0] win_c, hin_c, hout_c;
    logic [ADDR_W-1:0] ana_cnt, syn_cnt;

    logic [NGRAIN-1:0] w_act, busy, cw_act, cw_done;
    logic [ADDR_W-1:0] w_n [NGRAIN];
    logic [ADDR_W-1:0] w_len [NGRAIN];
    logic [ADDR_W-1:0] cw_n [NGRAIN];
    logic [ADDR_W-1:0] cw_len [NGRAIN];
    logic [ADDR_W-1:0] dl [NGRAIN];
    logic [ADDR_W-1:0] wt [NGRAIN];
    logic signed [PW-1:0] prod [NGRAIN];
    logic signed [PW-1:0] gmem [NGRAIN][MAX_WIN];

    logic          lat_vld, nl_vld;
    logic [GW-1:0] lat_buf, nl_buf, alloc_buf;
    logic [ADDR_W-1:0] nl_len;

    logic [NVOICE-1:0] v_act, cv_act;
    logic [GW-1:0]     v_buf [NVOICE];
    logic [GW-1:0]     cv_buf [NVOICE];
    logic [ADDR_W-1:0] v_n [NVOICE];
    logic [ADDR_W-1:0] v_len [NVOICE];
    logic [ADDR_W-1:0] cv_n [NVOICE];
    logic [ADDR_W-1:0] cv_len [NVOICE];
    logic signed [PW-1:0] rd_q [NVOICE];

    logic          strobe, alloc_ok, start, ovr_evt, epoch, bind_ok, vdrop_evt;
    logic [VW-1:0] bind_v;
    logic          s1_vld, s1_byp;
    logic [DATA_W-1:0] s1_din, sat;
    logic signed [SW-1:0] sum, shv;

    function automatic logic [ADDR_W-1:0] clamp_hop(input logic [ADDR_W-1:0] h,
                                                    input logic [ADDR_W-1:0] lim);
        if (h == '0) return ADDR_W'(1);
        if (h > lim) return lim;
        return h;
    endfunction

    always_comb begin
        win_c = win_len;
        if (win_len < ADDR_W'(4))            win_c = ADDR_W'(4);
        else if (win_len > ADDR_W'(MAX_WIN)) win_c = ADDR_W'(MAX_WIN);
        hin_c  = clamp_hop(hop_in, win_c);
        hout_c = clamp_hop(hop_out, win_c);
    end

    // Grain start, write view, latest-grain forwarding and voice binding for this strobe
    always_comb begin
        strobe = enable & sample_valid;
        for (int g = 0; g < NGRAIN; g++) begin
            busy[g] = w_act[g] | (lat_vld && lat_buf == GW'(g));
            for (int v = 0; v < NVOICE; v++)
                if (v_act[v] && v_buf[v] == GW'(g)) busy[g] = 1'b1;
        end
        alloc_ok  = 1'b0;
        alloc_buf = '0;
        for (int g = NGRAIN - 1; g >= 0; g--)
            if (!busy[g]) begin
                alloc_ok  = 1'b1;
                alloc_buf = GW'(g);
            end
        start   = strobe && ana_cnt == '0 && alloc_ok;
        ovr_evt = strobe && ana_cnt == '0 && !alloc_ok;

        nl_vld = lat_vld;
        nl_buf = lat_buf;
        nl_len = w_len[lat_buf];
        for (int g = 0; g < NGRAIN; g++) begin
            cw_act[g] = w_act[g];
            cw_n[g]   = w_n[g];
            cw_len[g] = w_len[g];
            if (start && alloc_buf == GW'(g)) begin
                cw_act[g] = 1'b1;
                cw_n[g]   = '0;
                cw_len[g] = win_c;
            end
            cw_done[g] = strobe && cw_act[g] && cw_n[g] == cw_len[g] - ADDR_W'(1);
            dl[g]   = cw_len[g] - ADDR_W'(1) - cw_n[g];
            wt[g]   = (cw_n[g] < dl[g]) ? cw_n[g] : dl[g];
            prod[g] = PW'($signed(din)) * PW'($signed({1'b0, wt[g]}));
            if (cw_done[g]) begin
                nl_vld = 1'b1;
                nl_buf = GW'(g);
                nl_len = cw_len[g];
            end
        end

        epoch   = strobe && syn_cnt == '0 && nl_vld;
        bind_ok = 1'b0;
        bind_v  = '0;
        for (int v = NVOICE - 1; v >= 0; v--)
            if (!v_act[v]) begin
                bind_ok = 1'b1;
                bind_v  = VW'(v);
            end
        vdrop_evt = epoch && !bind_ok;
        for (int v = 0; v < NVOICE; v++) begin
            cv_act[v] = v_act[v];
            cv_buf[v] = v_buf[v];
            cv_n[v]   = v_n[v];
            cv_len[v] = v_len[v];
            if (epoch && bind_ok && bind_v == VW'(v)) begin
                cv_act[v] = 1'b1;
                cv_buf[v] = nl_buf;
                cv_n[v]   = '0;
                cv_len[v] = nl_len;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ana_cnt    <= '0;
            syn_cnt    <= '0;
            w_act      <= '0;
            v_act      <= '0;
            lat_vld    <= 1'b0;
            lat_buf    <= '0;
            overrun    <= 1'b0;
            voice_drop <= 1'b0;
            for (int g = 0; g < NGRAIN; g++) begin
                w_n[g]   <= '0;
                w_len[g] <= '0;
            end
            for (int v = 0; v < NVOICE; v++) begin
                v_buf[v] <= '0;
                v_n[v]   <= '0;
                v_len[v] <= '0;
            end
        end else if (!enable) begin
            ana_cnt <= '0;
            syn_cnt <= '0;
            w_act   <= '0;
            v_act   <= '0;
            lat_vld <= 1'b0;
        end else if (sample_valid) begin
            ana_cnt <= (ana_cnt >= hin_c - ADDR_W'(1)) ? '0 : ana_cnt + ADDR_W'(1);
            syn_cnt <= (syn_cnt >= hout_c - ADDR_W'(1)) ? '0 : syn_cnt + ADDR_W'(1);
            for (int g = 0; g < NGRAIN; g++) begin
                w_act[g] <= cw_act[g] & ~cw_done[g];
                w_n[g]   <= cw_n[g] + ADDR_W'(1);
                w_len[g] <= cw_len[g];
            end
            lat_vld <= nl_vld;
            lat_buf <= nl_buf;
            for (int v = 0; v < NVOICE; v++) begin
                v_act[v] <= cv_act[v] && cv_n[v] != cv_len[v] - ADDR_W'(1);
                v_buf[v] <= cv_buf[v];
                v_n[v]   <= cv_n[v] + ADDR_W'(1);
                v_len[v] <= cv_len[v];
            end
            if (ovr_evt)   overrun    <= 1'b1;
            if (vdrop_evt) voice_drop <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (strobe)
            for (int g = 0; g < NGRAIN; g++)
                if (cw_act[g]) gmem[g][cw_n[g]] <= prod[g];
    end

    always_comb begin
        sum = '0;
        for (int v = 0; v < NVOICE; v++) sum = sum + SW'(rd_q[v]);
        shv = sum >>> out_shift;
        if (shv[SW-1:DATA_W-1] != {(SW-DATA_W+1){shv[SW-1]}})
            sat = shv[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat = shv[DATA_W-1:0];
    end

    // Bypass samples travel the same two-stage pipe so latency is mode-independent
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_vld     <= 1'b0;
            s1_byp     <= 1'b0;
            s1_din     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int v = 0; v < NVOICE; v++) rd_q[v] <= '0;
        end else begin
            s1_vld     <= sample_valid;
            dout_valid <= s1_vld;
            if (sample_valid) begin
                s1_byp <= ~enable;
                s1_din <= din;
                for (int v = 0; v < NVOICE; v++)
                    rd_q[v] <= (enable && cv_act[v]) ? gmem[cv_buf[v]][cv_n[v]] : '0;
            end
            if (s1_vld) dout <= s1_byp ? s1_din : sat;
        end
    end

endmodule
